// File: rtl/rtc_pkg.sv
// rtc_pkg
//   Shared definitions for the RTC power-up programming logic:
//   - sequencer state encoding
//   - RTC register address map
//   - the power-up init table, exposed as rtc_init_entry(idx) -> {addr, data}
package rtc_pkg;

  localparam int RTC_ADDR_W = 8;
  localparam int RTC_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_REQ    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // RTC register map
  localparam logic [7:0] RTC_REG_SECONDS = 8'h00;
  localparam logic [7:0] RTC_REG_MINUTES = 8'h01;
  localparam logic [7:0] RTC_REG_HOURS   = 8'h02;
  localparam logic [7:0] RTC_REG_DAY     = 8'h03;
  localparam logic [7:0] RTC_REG_DATE    = 8'h04;
  localparam logic [7:0] RTC_REG_MONTH   = 8'h05;
  localparam logic [7:0] RTC_REG_YEAR    = 8'h06;
  localparam logic [7:0] RTC_REG_ALARM1  = 8'h07;
  localparam logic [7:0] RTC_REG_ALARM2  = 8'h0B;
  localparam logic [7:0] RTC_REG_CONTROL = 8'h0E;
  localparam logic [7:0] RTC_REG_STATUS  = 8'h0F;
  localparam logic [7:0] RTC_REG_TRICKLE = 8'h10;

  typedef struct packed {
    logic [RTC_ADDR_W-1:0] addr;
    logic [RTC_DATA_W-1:0] data;
  } rtc_entry_t;

  // Control/status go first so the oscillator and interrupts are in a known
  // state before the time-of-day registers are written.
  function automatic rtc_entry_t rtc_init_entry(input logic [3:0] idx);
    rtc_entry_t e;
    case (idx)
      4'd0:    e = {RTC_REG_CONTROL, 8'h1C};
      4'd1:    e = {RTC_REG_STATUS,  8'h00};
      4'd2:    e = {RTC_REG_SECONDS, 8'h00};
      4'd3:    e = {RTC_REG_MINUTES, 8'h30};
      4'd4:    e = {RTC_REG_HOURS,   8'h12};
      4'd5:    e = {RTC_REG_DAY,     8'h01};
      4'd6:    e = {RTC_REG_DATE,    8'h15};
      4'd7:    e = {RTC_REG_MONTH,   8'h06};
      4'd8:    e = {RTC_REG_YEAR,    8'h24};
      4'd9:    e = {RTC_REG_ALARM1,  8'h00};
      4'd10:   e = {RTC_REG_ALARM2,  8'h00};
      4'd11:   e = {RTC_REG_TRICKLE, 8'hA5};
      default: e = {RTC_REG_STATUS,  8'h00};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/settle_counter.sv
// settle_counter
//   Gap counter that runs 0..MAX_COUNT while enabled and flags the terminal
//   count combinationally. It wraps to 0 on terminal count and never exceeds
//   MAX_COUNT; clear forces it to 0.
// Ports:
//   clk      in  system clock
//   reset    in  asynchronous active-high reset
//   enable   in  count this cycle
//   clear    in  synchronous clear (wins over enable)
//   terminal out enable && count == MAX_COUNT
module settle_counter #(
  parameter int MAX_COUNT = 48
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic terminal
);

  localparam int CW = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_COUNT);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  assign terminal = enable && (count_reg == LAST);

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable) begin
      count_next = terminal ? '0 : count_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/rtc_init_sequencer.sv
// rtc_init_sequencer
//   Walks the RTC init table and issues each (addr, data) pair as a write
//   request over a req/ack handshake, with a settle gap of SETTLE_CYCLES+1
//   clocks after every ack. An ack that never comes flags a sticky error.
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   start             one-cycle pulse, honoured only in IDLE
//   abort             synchronous abort back to IDLE (highest priority)
//   wr_req            write request, held until wr_ack
//   wr_addr, wr_data  register address/data, stable while wr_req=1
//   wr_ack            one-cycle completion pulse from the bus engine
//   step              current table index
//   busy              high in LOAD/REQ/SETTLE
//   done              one-cycle pulse after the last settle gap
//   error             sticky ack-timeout flag, cleared by the next start
module rtc_init_sequencer
  import rtc_pkg::*;
#(
  parameter int NUM_WRITES     = 8,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int SETTLE_CYCLES  = 48,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ack,
  output logic [3:0]        step,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [3:0] LAST_STEP = 4'(NUM_WRITES - 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // The timeout fires on the cycle whose increment would bring the counter
  // to TIMEOUT_CYCLES, so REQ lasts at most TIMEOUT_CYCLES clocks.
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t            state_reg, state_next;
  logic [3:0]        step_reg, step_next;
  logic [TW-1:0]     to_cnt_reg, to_cnt_next;
  logic              error_reg, error_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] data_reg, data_next;
  rtc_entry_t        entry;
  logic              settle_tc;

  settle_counter #(
    .MAX_COUNT(SETTLE_CYCLES)
  ) u_settle (
    .clk     (clk),
    .reset   (reset),
    .enable  (state_reg == ST_SETTLE),
    .clear   (state_reg != ST_SETTLE),
    .terminal(settle_tc)
  );

  always_comb begin
    state_next  = state_reg;
    step_next   = step_reg;
    to_cnt_next = to_cnt_reg;
    error_next  = error_reg;
    addr_next   = addr_reg;
    data_next   = data_reg;
    entry       = rtc_init_entry(step_reg);

    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_next = ST_LOAD;
            step_next  = '0;
            error_next = 1'b0;
          end
        end
        ST_LOAD: begin
          addr_next   = ADDR_W'(entry.addr);
          data_next   = DATA_W'(entry.data);
          to_cnt_next = '0;
          state_next  = ST_REQ;
        end
        ST_REQ: begin
          // Ack is checked first so an ack on the timeout cycle still succeeds.
          if (wr_ack) begin
            state_next = ST_SETTLE;
          end else if (to_cnt_reg == TO_LAST) begin
            error_next = 1'b1;
            state_next = ST_IDLE;
          end else begin
            to_cnt_next = to_cnt_reg + TW'(1);
          end
        end
        ST_SETTLE: begin
          if (settle_tc) begin
            if (step_reg == LAST_STEP) begin
              state_next = ST_DONE;
            end else begin
              step_next  = step_reg + 4'd1;
              state_next = ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          state_next = ST_IDLE;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      step_reg   <= '0;
      to_cnt_reg <= '0;
      error_reg  <= 1'b0;
      addr_reg   <= '0;
      data_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      step_reg   <= step_next;
      to_cnt_reg <= to_cnt_next;
      error_reg  <= error_next;
      addr_reg   <= addr_next;
      data_reg   <= data_next;
    end
  end

  // Decoded straight from the state register so reset drops wr_req at once.
  assign wr_req  = (state_reg == ST_REQ);
  assign busy    = (state_reg == ST_LOAD) || (state_reg == ST_REQ) ||
                   (state_reg == ST_SETTLE);
  assign done    = (state_reg == ST_DONE);
  assign error   = error_reg;
  assign step    = step_reg;
  assign wr_addr = addr_reg;
  assign wr_data = data_reg;

endmodule
